tx_release_scheduler: RTL and testbench

//  Timestamp-gated frame release controller on the GMII TX side. It walks the TX frame slot

---
 rtl/tx_release_scheduler_pkg.sv | 31 +++
 rtl/tx_release_scheduler_if.sv | 18 +
 rtl/tx_release_scheduler_ts_compare.sv | 22 ++
 rtl/tx_release_scheduler.sv | 121 ++++++++++++
 tb/tb_tx_release_scheduler.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/tx_release_scheduler_pkg.sv
// Shared definitions for the timestamp-gated TX release scheduler:
// state encodings, header layout and default frame length bounds.
package tx_release_scheduler_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR_RD  = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int HDR_WORDS_DEF = 7;
    localparam int OFF_LEN       = 0;
    localparam int OFF_TS        = 1;
    localparam int OFF_HASH      = 5;
    localparam int HDR_RD_WORDS  = 5;

    localparam logic [15:0] MIN_LEN_DEF = 16'd60;
    localparam logic [15:0] MAX_LEN_DEF = 16'd1518;

    typedef struct packed {
        logic [15:0] len;
        logic [63:0] ts;
    } tx_hdr_t;

    // Payload words occupied by a frame; computed in 15 bits so len 16383 does not wrap.
    function automatic logic [13:0] payload_words(input logic [15:0] len);
        logic [14:0] half;
        half = ({1'b0, len[13:0]} + 15'd1) >> 1;
        return half[13:0];
    endfunction

endpackage

// File: rtl/tx_release_scheduler_if.sv
// Second read port into the TX slot RAM used by the release scheduler.
// Read data is valid one cycle after the address is presented.
interface tx_release_scheduler_if;

    logic [13:0] sched_mem_addr;
    logic [15:0] sched_mem_q;

    modport master (
        output sched_mem_addr,
        input  sched_mem_q
    );

    modport slave (
        input  sched_mem_addr,
        output sched_mem_q
    );

endinterface

// File: rtl/tx_release_scheduler_ts_compare.sv
// Timestamp due / late comparator for the release scheduler.
// Compare is single-cycle so the release decision lands in WAIT_TIME itself.
module tx_ts_compare #(
    parameter logic [63:0] LATE_THRESH = 64'd0
) (
    input  logic [63:0] global_counter,
    input  logic [63:0] tx_ts,
    output logic        due,
    output logic        late
);

    logic [64:0] sum;
    logic [63:0] limit;

    // ts + threshold saturates instead of wrapping past 2^64-1
    assign sum   = {1'b0, tx_ts} + {1'b0, LATE_THRESH};
    assign limit = sum[64] ? '1 : sum[63:0];

    assign due  = (tx_ts == 64'd0) || (global_counter >= tx_ts);
    assign late = (tx_ts != 64'd0) && (global_counter > limit);

endmodule

// File: rtl/tx_release_scheduler.sv
// Releases TX frames to the GMII sender once global_counter reaches each frame's timestamp.
// Optional `TX_SCHED_STATS_EN adds stat_tx_frames / stat_tx_late counters.
module tx_release_scheduler
    import tx_release_scheduler_pkg::*;
#(
    parameter int          HDR_WORDS   = HDR_WORDS_DEF,
    parameter logic [63:0] LATE_THRESH = 64'd0,
    parameter logic [15:0] MIN_LEN     = MIN_LEN_DEF,
    parameter logic [15:0] MAX_LEN     = MAX_LEN_DEF
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst,
    input  logic [63:0] global_counter,
    input  logic        sched_en,
    input  logic [13:0] host_wr_ptr,
    tx_release_scheduler_if.master mem,
    output logic [13:0] sched_wr_ptr,
    output logic        sched_busy,
    output logic        sched_late,
    output logic        sched_len_err
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [31:0] stat_tx_frames,
    output logic [31:0] stat_tx_late
`endif
);

    logic [1:0]  state;
    logic [13:0] hdr_ptr;
    logic [2:0]  rd_cnt;
    tx_hdr_t     hdr;
    logic        late_q;
    logic        ts_due;
    logic        ts_late;
    logic        len_bad;
    logic [13:0] nxt_ptr;

    tx_ts_compare #(
        .LATE_THRESH (LATE_THRESH)
    ) u_cmp (
        .global_counter (global_counter),
        .tx_ts          (hdr.ts),
        .due            (ts_due),
        .late           (ts_late)
    );

    assign len_bad    = (hdr.len < MIN_LEN) || (hdr.len > MAX_LEN);
    assign nxt_ptr    = hdr_ptr + 14'(HDR_WORDS) + payload_words(hdr.len);
    assign sched_busy = (state != ST_IDLE);

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            state              <= ST_IDLE;
            hdr_ptr            <= '0;
            rd_cnt             <= '0;
            hdr                <= '0;
            late_q             <= 1'b0;
            sched_wr_ptr       <= '0;
            mem.sched_mem_addr <= '0;
            sched_late         <= 1'b0;
            sched_len_err      <= 1'b0;
        end else begin
            sched_late    <= 1'b0;
            sched_len_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (sched_en && (hdr_ptr != host_wr_ptr)) begin
                        state              <= ST_HDR_RD;
                        rd_cnt             <= '0;
                        mem.sched_mem_addr <= hdr_ptr;
                    end
                end
                ST_HDR_RD: begin
                    rd_cnt <= rd_cnt + 3'd1;
                    if (rd_cnt < 3'(HDR_RD_WORDS - 1))
                        mem.sched_mem_addr <= hdr_ptr + 14'(rd_cnt) + 14'd1;
                    // rd_cnt-1 is the header word offset returned this cycle
                    case (rd_cnt)
                        3'd1: hdr.len        <= mem.sched_mem_q;
                        3'd2: hdr.ts[63:48]  <= mem.sched_mem_q;
                        3'd3: hdr.ts[47:32]  <= mem.sched_mem_q;
                        3'd4: hdr.ts[31:16]  <= mem.sched_mem_q;
                        3'd5: begin
                            hdr.ts[15:0] <= mem.sched_mem_q;
                            state        <= ST_WAIT;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT: begin
                    if (ts_due) begin
                        state  <= ST_RELEASE;
                        late_q <= ts_late;
                    end
                end
                ST_RELEASE: begin
                    sched_wr_ptr  <= nxt_ptr;
                    hdr_ptr       <= nxt_ptr;
                    sched_late    <= late_q;
                    sched_len_err <= len_bad;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TX_SCHED_STATS_EN
    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            stat_tx_frames <= '0;
            stat_tx_late   <= '0;
        end else if (state == ST_RELEASE) begin
            stat_tx_frames <= stat_tx_frames + 32'd1;
            if (late_q)
                stat_tx_late <= stat_tx_late + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_release_scheduler.sv
// Directed bench for tx_release_scheduler with a registered-read slot RAM model.
// Build with +define+TX_SCHED_STATS_EN to also check the statistics counters.
module tb_tx_release_scheduler;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [63:0] global_counter;
    logic        sched_en;
    logic [13:0] host_wr_ptr;
    logic [13:0] sched_wr_ptr;
    logic        sched_busy;
    logic        sched_late;
    logic        sched_len_err;
`ifdef TX_SCHED_STATS_EN
    logic [31:0] stat_tx_frames;
    logic [31:0] stat_tx_late;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] ram [16384];

    tx_release_scheduler_if mif ();

    tx_release_scheduler #(
        .LATE_THRESH (64'd10)
    ) dut (
        .gmii_tx_clk    (clk),
        .sys_rst        (sys_rst),
        .global_counter (global_counter),
        .sched_en       (sched_en),
        .host_wr_ptr    (host_wr_ptr),
        .mem            (mif),
        .sched_wr_ptr   (sched_wr_ptr),
        .sched_busy     (sched_busy),
        .sched_late     (sched_late),
        .sched_len_err  (sched_len_err)
`ifdef TX_SCHED_STATS_EN
        ,
        .stat_tx_frames (stat_tx_frames),
        .stat_tx_late   (stat_tx_late)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) mif.sched_mem_q <= ram[mif.sched_mem_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic put_frame(input int p, input logic [15:0] len, input logic [63:0] ts);
        ram[(p + 0) % 16384] = len;
        ram[(p + 1) % 16384] = ts[63:48];
        ram[(p + 2) % 16384] = ts[47:32];
        ram[(p + 3) % 16384] = ts[31:16];
        ram[(p + 4) % 16384] = ts[15:0];
        ram[(p + 5) % 16384] = 16'hbeef;
        ram[(p + 6) % 16384] = 16'hcafe;
    endtask

    task automatic wait_rel(input logic [13:0] exp_ptr, input logic exp_late,
                            input logic exp_err);
        logic [13:0] start;
        int n;
        start = sched_wr_ptr;
        n = 0;
        while (sched_wr_ptr == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("release_timeout", 64'(n < 300), 64'd1);
        chk("wr_ptr", 64'(sched_wr_ptr), 64'(exp_ptr));
        chk("late_pulse", 64'(sched_late), 64'(exp_late));
        chk("len_err_pulse", 64'(sched_len_err), 64'(exp_err));
        @(negedge clk);
        chk("pulses_clear", 64'({sched_late, sched_len_err}), 64'd0);
    endtask

    initial begin
        sys_rst        = 1'b1;
        global_counter = 64'd0;
        sched_en       = 1'b1;
        host_wr_ptr    = 14'd0;
        cycles(3);
        chk("rst_wr_ptr", 64'(sched_wr_ptr), 64'd0);
        chk("rst_addr", 64'(mif.sched_mem_addr), 64'd0);
        chk("rst_busy", 64'(sched_busy), 64'd0);
        chk("rst_pulses", 64'({sched_late, sched_len_err}), 64'd0);
        sys_rst = 1'b0;
        cycles(5);
        chk("idle_no_work", 64'(sched_busy), 64'd0);

        // len 60, ts 0: released immediately, 0 -> 37
        put_frame(0, 16'd60, 64'd0);
        host_wr_ptr = 14'd37;
        wait_rel(14'd37, 1'b0, 1'b0);
        chk("idle_after_rel", 64'(sched_busy), 64'd0);

        // ts 1000 held while counter below it, 37 -> 94
        put_frame(37, 16'd100, 64'd1000);
        global_counter = 64'd900;
        host_wr_ptr    = 14'd94;
        cycles(20);
        chk("hold_ptr", 64'(sched_wr_ptr), 64'd37);
        chk("hold_busy", 64'(sched_busy), 64'd1);
        global_counter = 64'd999;
        cycles(3);
        chk("hold_999", 64'(sched_wr_ptr), 64'd37);
        global_counter = 64'd1000;
        wait_rel(14'd94, 1'b0, 1'b0);

        // ts 100, counter 500 > 100+10: late release, 94 -> 141
        put_frame(94, 16'd80, 64'd100);
        global_counter = 64'd500;
        host_wr_ptr    = 14'd141;
        wait_rel(14'd141, 1'b1, 1'b0);

        // len 20 is short but still released, 141 -> 158
        put_frame(141, 16'd20, 64'd0);
        host_wr_ptr = 14'd158;
        wait_rel(14'd158, 1'b0, 1'b1);
`ifdef TX_SCHED_STATS_EN
        chk("stat_frames_4", 64'(stat_tx_frames), 64'd4);
        chk("stat_late_1", 64'(stat_tx_late), 64'd1);
`endif

        // reset in the middle of the header read
        put_frame(158, 16'd60, 64'd0);
        host_wr_ptr = 14'd195;
        cycles(3);
        chk("mid_hdr_busy", 64'(sched_busy), 64'd1);
        sys_rst     = 1'b1;
        host_wr_ptr = 14'd0;
        @(negedge clk);
        chk("midrst_wr_ptr", 64'(sched_wr_ptr), 64'd0);
        chk("midrst_addr", 64'(mif.sched_mem_addr), 64'd0);
        chk("midrst_busy", 64'(sched_busy), 64'd0);
        chk("midrst_pulses", 64'({sched_late, sched_len_err}), 64'd0);
`ifdef TX_SCHED_STATS_EN
        chk("midrst_frames", 64'(stat_tx_frames), 64'd0);
        chk("midrst_late", 64'(stat_tx_late), 64'd0);
`endif
        sys_rst = 1'b0;
        cycles(2);

        // three oversize frames (len 10906 -> 5460 words each) walk up to 16380
        for (int k = 0; k < 3; k++) begin
            put_frame(k * 5460, 16'd10906, 64'd0);
            host_wr_ptr = 14'((k + 1) * 5460);
            wait_rel(14'((k + 1) * 5460), 1'b0, 1'b1);
        end

        // 16380 + 7 + 32 wraps to 35
        put_frame(16380, 16'd64, 64'd0);
        host_wr_ptr = 14'd35;
        wait_rel(14'd35, 1'b0, 1'b0);

        // disable while waiting: current frame completes, queued one stays put
        global_counter = 64'd0;
        put_frame(35, 16'd60, 64'd5000);
        put_frame(72, 16'd60, 64'd0);
        host_wr_ptr = 14'd109;
        cycles(12);
        chk("wait_busy", 64'(sched_busy), 64'd1);
        chk("wait_ptr", 64'(sched_wr_ptr), 64'd35);
        sched_en       = 1'b0;
        global_counter = 64'd5000;
        wait_rel(14'd72, 1'b0, 1'b0);
        cycles(20);
        chk("dis_ptr", 64'(sched_wr_ptr), 64'd72);
        chk("dis_busy", 64'(sched_busy), 64'd0);
        sched_en = 1'b1;
        wait_rel(14'd109, 1'b0, 1'b0);
`ifdef TX_SCHED_STATS_EN
        chk("stat_frames_6", 64'(stat_tx_frames), 64'd6);
        chk("stat_late_0", 64'(stat_tx_late), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
